// File: rtl/sorter_pkg.sv
// Shared types and defaults for the sort frame controller and its result FIFO.
package sorter_pkg;

    localparam int unsigned N_DEF      = 24;
    localparam int unsigned W_DEF      = 8;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned FIFO_AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned FIFO_CW    = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DISCARD,
        ST_SETTLE,
        ST_DRAIN,
        ST_EMPTY,
        ST_CLEAR
    } state_t;

endpackage

// File: rtl/sort_res_fifo.sv
// Four-entry result FIFO; each entry carries a sorted element and its end-of-frame tag.
module sort_res_fifo
    import sorter_pkg::*;
#(
    parameter int unsigned W = W_DEF
) (
    input  logic               clk,
    input  logic               nreset,
    input  logic               clr,
    input  logic               push,
    input  logic [W-1:0]       push_data,
    input  logic               push_last,
    input  logic               pop,
    output logic [W-1:0]       head_data,
    output logic               head_last,
    output logic               head_valid,
    output logic [FIFO_CW-1:0] count
);

    logic [W-1:0]          mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] last_mem;
    logic [FIFO_AW-1:0]    wr_ptr;
    logic [FIFO_AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (!nreset || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
            if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
            count <= count + FIFO_CW'(push) - FIFO_CW'(pop);
        end
    end

    // Storage is not reset; the occupancy count masks stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr]      <= push_data;
            last_mem[wr_ptr] <= push_last;
        end
    end

    assign head_valid = (count != '0);
    assign head_data  = head_valid ? mem[rd_ptr] : '0;
    assign head_last  = head_valid && last_mem[rd_ptr];

endmodule

// File: rtl/sort_frame_ctrl.sv
// Frame controller: loads a frame into an external sorter, drains the sorted
// results through a small FIFO and clears the sorter between frames.
module sort_frame_ctrl
    import sorter_pkg::*;
#(
    parameter int unsigned N       = N_DEF,
    parameter int unsigned W       = W_DEF,
    parameter int unsigned SETTLE  = 2,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         nreset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [W-1:0] srt_data,
    output logic         srt_valid,
    output logic         srt_flush,
    output logic         srt_clear,
    input  logic [W-1:0] srt_res,
    input  logic         srt_res_v,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    output logic         out_last,
    input  logic         out_ready,
    output logic         busy,
    output logic         err_overflow,
    output logic         err_timeout
);

    localparam int unsigned CW = $clog2(N + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned SW = $clog2(SETTLE + 1);

    state_t             state, nxt;
    logic [CW-1:0]      cnt, cnt_d, issued, issued_d, rcvd, rcvd_d;
    logic [TW-1:0]      tmo, tmo_d;
    logic [SW-1:0]      stl, stl_d;
    logic [FIFO_CW-1:0] occ, occ_d;
    logic [W-1:0]       srt_data_d;
    logic               in_ready_d, srt_valid_d, srt_flush_d, srt_clear_d, busy_d;
    logic               err_ovf_d, err_tmo_d, fifo_clr;
    logic               acc, load, push, pop, push_last;

    assign acc       = in_valid && in_ready;
    assign load      = acc && (state == ST_IDLE || state == ST_LOAD);
    assign push      = srt_res_v && (state == ST_DRAIN);
    assign pop       = out_valid && out_ready;
    assign push_last = ((rcvd + CW'(1)) == cnt);

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            issued       <= '0;
            rcvd         <= '0;
            tmo          <= '0;
            stl          <= '0;
            in_ready     <= 1'b0;
            srt_data     <= '0;
            srt_valid    <= 1'b0;
            srt_flush    <= 1'b0;
            srt_clear    <= 1'b1;
            busy         <= 1'b0;
            err_overflow <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            state        <= nxt;
            cnt          <= cnt_d;
            issued       <= issued_d;
            rcvd         <= rcvd_d;
            tmo          <= tmo_d;
            stl          <= stl_d;
            in_ready     <= in_ready_d;
            srt_data     <= srt_data_d;
            srt_valid    <= srt_valid_d;
            srt_flush    <= srt_flush_d;
            srt_clear    <= srt_clear_d;
            busy         <= busy_d;
            err_overflow <= err_ovf_d;
            err_timeout  <= err_tmo_d;
        end
    end

    // Outputs are registered from next-cycle values so they line up with the state they describe.
    always_comb begin
        nxt         = state;
        cnt_d       = cnt;
        issued_d    = issued + CW'(srt_flush);
        rcvd_d      = rcvd + CW'(push);
        tmo_d       = tmo;
        stl_d       = stl;
        err_ovf_d   = err_overflow;
        err_tmo_d   = err_timeout;
        fifo_clr    = 1'b0;
        srt_data_d  = srt_data;
        srt_valid_d = load;

        if (load) begin
            srt_data_d = in_data;
            cnt_d      = cnt + CW'(1);
        end

        case (state)
            ST_IDLE, ST_LOAD: begin
                if (load) begin
                    if (in_last) begin
                        nxt = ST_SETTLE;
                    end else if (cnt_d == CW'(N)) begin
                        nxt       = ST_DISCARD;
                        err_ovf_d = 1'b1;
                    end else begin
                        nxt = ST_LOAD;
                    end
                end
            end
            ST_DISCARD: begin
                if (acc && in_last) nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                // Only idle cycles count, so the trailing load strobe is not part of the gap.
                if (!srt_valid) begin
                    if (stl == SW'(SETTLE - 1)) nxt = ST_DRAIN;
                    else                        stl_d = stl + SW'(1);
                end
            end
            ST_DRAIN: begin
                tmo_d = push ? '0 : tmo + TW'(1);
                if (push && push_last) begin
                    nxt = ST_EMPTY;
                end else if (!push && tmo == TW'(TIMEOUT - 1)) begin
                    nxt       = ST_CLEAR;
                    err_tmo_d = 1'b1;
                    fifo_clr  = 1'b1;
                end
            end
            ST_EMPTY: begin
                if (occ == '0) nxt = ST_CLEAR;
            end
            ST_CLEAR: begin
                nxt      = ST_IDLE;
                cnt_d    = '0;
                issued_d = '0;
                rcvd_d   = '0;
                tmo_d    = '0;
                stl_d    = '0;
            end
            default: nxt = ST_IDLE;
        endcase

        occ_d       = fifo_clr ? '0 : occ + FIFO_CW'(push) - FIFO_CW'(pop);
        // With at most one entry queued, three in-flight results still fit in the FIFO.
        srt_flush_d = (nxt == ST_DRAIN) && (occ_d <= FIFO_CW'(1)) && (issued_d < cnt_d);
        in_ready_d  = ((nxt == ST_IDLE || nxt == ST_LOAD) && (cnt_d < CW'(N))) || (nxt == ST_DISCARD);
        srt_clear_d = (nxt == ST_CLEAR);
        busy_d      = (nxt != ST_IDLE);
    end

    sort_res_fifo #(.W(W)) u_fifo (
        .clk        (clk),
        .nreset     (nreset),
        .clr        (fifo_clr),
        .push       (push),
        .push_data  (srt_res),
        .push_last  (push_last),
        .pop        (pop),
        .head_data  (out_data),
        .head_last  (out_last),
        .head_valid (out_valid),
        .count      (occ)
    );

endmodule

// File: tb/tb_sort_frame_ctrl.sv
// Directed bench for sort_frame_ctrl with a behavioural sorter returning results two cycles after flush.
module tb_sort_frame_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         nreset = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic [W-1:0] srt_data;
    logic         srt_valid, srt_flush, srt_clear;
    logic [W-1:0] srt_res = '0;
    logic         srt_res_v = 1'b0;
    logic [W-1:0] out_data;
    logic         out_valid, out_last;
    logic         out_ready = 1'b1;
    logic         busy, err_overflow, err_timeout;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sort_frame_ctrl #(.N(24), .W(8), .SETTLE(2), .TIMEOUT(64)) dut (
        .clk(clk), .nreset(nreset),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .srt_data(srt_data), .srt_valid(srt_valid), .srt_flush(srt_flush), .srt_clear(srt_clear),
        .srt_res(srt_res), .srt_res_v(srt_res_v),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .err_overflow(err_overflow), .err_timeout(err_timeout)
    );

    // Behavioural sorter: returns the smallest stored element two cycles after each flush.
    logic         mute = 1'b0;
    logic [W-1:0] store[$];
    logic [W-1:0] p1_d = '0;
    logic         p1_v = 1'b0;

    always @(posedge clk) begin
        int mi;
        if (srt_clear === 1'b1) begin
            store.delete();
            p1_v <= 1'b0;
        end else begin
            if (srt_valid === 1'b1) store.push_back(srt_data);
            p1_v <= 1'b0;
            if (srt_flush === 1'b1 && !mute && store.size() > 0) begin
                mi = 0;
                for (int i = 1; i < store.size(); i++)
                    if (store[i] < store[mi]) mi = i;
                p1_d <= store[mi];
                p1_v <= 1'b1;
                store.delete(mi);
            end
        end
        srt_res   <= p1_d;
        srt_res_v <= p1_v;
    end

    // Monitor on the falling edge; tests take queue sizes as marks before each scenario.
    int           cyc = 0;
    int           occ_m = 0;
    int           flush_viol = 0;
    logic [W-1:0] ld_q[$];
    int           ld_cyc[$];
    int           acc_cyc[$];
    int           fl_cyc[$];
    int           clr_cyc[$];
    logic [W-1:0] od_q[$];
    logic         ol_q[$];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (nreset) begin
            if (in_valid && in_ready) acc_cyc.push_back(cyc);
            if (srt_valid) begin
                ld_q.push_back(srt_data);
                ld_cyc.push_back(cyc);
            end
            if (srt_flush) begin
                fl_cyc.push_back(cyc);
                if (occ_m >= 2) flush_viol <= flush_viol + 1;
            end
            if (srt_clear) clr_cyc.push_back(cyc);
            if (out_valid && out_ready) begin
                od_q.push_back(out_data);
                ol_q.push_back(out_last);
            end
        end
        if (!nreset || srt_clear)
            occ_m <= 0;
        else
            occ_m <= occ_m + (srt_res_v ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
    end

    logic [W-1:0] frm[$];

    task automatic send_frame();
        for (int i = 0; i < frm.size(); i++) begin
            int t;
            t = 0;
            in_data  = frm[i];
            in_valid = 1'b1;
            in_last  = (i == frm.size() - 1);
            @(negedge clk);
            while (!in_ready && t < 100) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                n_cmp++;
                n_fail++;
                $display("FAIL send_beat%0d: in_ready=%b required=1 within 100 cycles", i, in_ready);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int t;
        t = 0;
        @(negedge clk);
        while (busy && t < budget) begin
            @(negedge clk);
            t++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_done: busy=%b required=0 within %0d cycles", name, busy, budget);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nreset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({in_ready, srt_valid, srt_flush, out_valid, out_last, busy} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {in_ready, srt_valid, srt_flush, out_valid, out_last, busy});
        end
        n_cmp++;
        if (srt_clear !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_clear: srt_clear=%b required=1", srt_clear);
        end
        n_cmp++;
        if ({err_overflow, err_timeout} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_err: got %b required 00", {err_overflow, err_timeout});
        end
        @(posedge clk);
        #1;
        nreset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int           b_ld, b_acc, b_fl, b_clr, b_od;
        logic [W-1:0] exp_q[$];
        logic         expl_q[$];
        b_ld = ld_q.size(); b_acc = acc_cyc.size(); b_fl = fl_cyc.size();
        b_clr = clr_cyc.size(); b_od = od_q.size();
        exp_q  = '{8'd1, 8'd3, 8'd5, 8'd9};
        expl_q = '{1'b0, 1'b0, 1'b0, 1'b1};
        frm = '{8'd5, 8'd3, 8'd9, 8'd1};
        out_ready = 1'b1;
        send_frame();
        wait_done(300, "basic");
        n_cmp++;
        if (ld_q.size() - b_ld != 4) begin
            n_fail++;
            $display("FAIL basic_loads: got %0d required 4", ld_q.size() - b_ld);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (ld_q[b_ld+i] !== frm[i] || ld_cyc[b_ld+i] != acc_cyc[b_acc+i] + 1) begin
                    n_fail++;
                    $display("FAIL basic_load%0d: data %0d at cycle %0d, required %0d at cycle %0d",
                             i, ld_q[b_ld+i], ld_cyc[b_ld+i], frm[i], acc_cyc[b_acc+i] + 1);
                end
            end
            n_cmp++;
            if (fl_cyc.size() <= b_fl || fl_cyc[b_fl] - ld_cyc[b_ld+3] - 1 != 2) begin
                n_fail++;
                $display("FAIL basic_settle: idle gap before first flush wrong, required 2");
            end
        end
        n_cmp++;
        if (od_q.size() - b_od != 4) begin
            n_fail++;
            $display("FAIL basic_count: got %0d results required 4", od_q.size() - b_od);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (od_q[b_od+i] !== exp_q[i] || ol_q[b_od+i] !== expl_q[i]) begin
                    n_fail++;
                    $display("FAIL basic_out%0d: got %0d/last %b required %0d/last %b",
                             i, od_q[b_od+i], ol_q[b_od+i], exp_q[i], expl_q[i]);
                end
            end
        end
        n_cmp++;
        if (clr_cyc.size() - b_clr != 1 || err_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_clear: clears=%0d ovf=%b required 1/0", clr_cyc.size() - b_clr, err_overflow);
        end
    endtask

    task automatic test_exact_n();
        int b_ld, b_od;
        b_ld = ld_q.size(); b_od = od_q.size();
        frm.delete();
        for (int i = 0; i < 24; i++) frm.push_back(W'(24 - i));
        send_frame();
        wait_done(500, "exact");
        n_cmp++;
        if (err_overflow !== 1'b0 || ld_q.size() - b_ld != 24) begin
            n_fail++;
            $display("FAIL exact_load: ovf=%b loads=%0d required 0/24", err_overflow, ld_q.size() - b_ld);
        end
        n_cmp++;
        if (od_q.size() - b_od != 24) begin
            n_fail++;
            $display("FAIL exact_count: got %0d required 24", od_q.size() - b_od);
        end else begin
            for (int i = 0; i < 24; i++) begin
                n_cmp++;
                if (od_q[b_od+i] !== W'(i + 1) || ol_q[b_od+i] !== (i == 23)) begin
                    n_fail++;
                    $display("FAIL exact_out%0d: got %0d/last %b required %0d/last %b",
                             i, od_q[b_od+i], ol_q[b_od+i], i + 1, (i == 23));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int           b_od, b_clr;
        logic [W-1:0] exp_q[$];
        logic         expl_q[$];
        b_od = od_q.size(); b_clr = clr_cyc.size();
        exp_q  = '{8'd10, 8'd200, 8'd42};
        expl_q = '{1'b0, 1'b1, 1'b1};
        frm = '{8'd200, 8'd10};
        send_frame();
        frm = '{8'd42};
        send_frame();
        wait_done(300, "b2b");
        n_cmp++;
        if (od_q.size() - b_od != 3) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d required 3", od_q.size() - b_od);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (od_q[b_od+i] !== exp_q[i] || ol_q[b_od+i] !== expl_q[i]) begin
                    n_fail++;
                    $display("FAIL b2b_out%0d: got %0d/last %b required %0d/last %b",
                             i, od_q[b_od+i], ol_q[b_od+i], exp_q[i], expl_q[i]);
                end
            end
        end
        n_cmp++;
        if (clr_cyc.size() - b_clr != 2) begin
            n_fail++;
            $display("FAIL b2b_clears: got %0d required 2", clr_cyc.size() - b_clr);
        end
    endtask

    task automatic test_backpressure();
        int           b_od, b_fl, b_viol, t;
        logic [W-1:0] exp_q[$];
        b_od = od_q.size(); b_fl = fl_cyc.size(); b_viol = flush_viol;
        exp_q = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        frm = '{8'd40, 8'd10, 8'd70, 8'd20, 8'd80, 8'd30, 8'd60, 8'd50};
        out_ready = 1'b0;
        send_frame();
        t = 0;
        while (fl_cyc.size() == b_fl && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (20) @(negedge clk);
        n_cmp++;
        if (fl_cyc.size() - b_fl != 4 || out_valid !== 1'b1 || od_q.size() != b_od) begin
            n_fail++;
            $display("FAIL bp_stall: flushes=%0d out_valid=%b popped=%0d required 4/1/0",
                     fl_cyc.size() - b_fl, out_valid, od_q.size() - b_od);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_done(300, "bp");
        n_cmp++;
        if (flush_viol != b_viol) begin
            n_fail++;
            $display("FAIL bp_occupancy: %0d flushes at occupancy>=2 required 0", flush_viol - b_viol);
        end
        n_cmp++;
        if (od_q.size() - b_od != 8) begin
            n_fail++;
            $display("FAIL bp_count: got %0d required 8", od_q.size() - b_od);
        end else begin
            for (int i = 0; i < 8; i++) begin
                n_cmp++;
                if (od_q[b_od+i] !== exp_q[i] || ol_q[b_od+i] !== (i == 7)) begin
                    n_fail++;
                    $display("FAIL bp_out%0d: got %0d/last %b required %0d/last %b",
                             i, od_q[b_od+i], ol_q[b_od+i], exp_q[i], (i == 7));
                end
            end
        end
    endtask

    task automatic test_overflow();
        int b_ld, b_od, b_acc;
        b_ld = ld_q.size(); b_od = od_q.size(); b_acc = acc_cyc.size();
        frm.delete();
        for (int i = 0; i < 25; i++) frm.push_back(W'(100 - 3 * i));
        send_frame();
        wait_done(500, "ovf");
        n_cmp++;
        if (err_overflow !== 1'b1 || acc_cyc.size() - b_acc != 25) begin
            n_fail++;
            $display("FAIL ovf_flag: ovf=%b accepted=%0d required 1/25", err_overflow, acc_cyc.size() - b_acc);
        end
        n_cmp++;
        if (ld_q.size() - b_ld != 24 || ld_q[ld_q.size()-1] !== 8'd31) begin
            n_fail++;
            $display("FAIL ovf_loads: loads=%0d last=%0d required 24/31",
                     ld_q.size() - b_ld, ld_q[ld_q.size()-1]);
        end
        n_cmp++;
        if (od_q.size() - b_od != 24) begin
            n_fail++;
            $display("FAIL ovf_count: got %0d required 24", od_q.size() - b_od);
        end else begin
            for (int i = 0; i < 24; i++) begin
                n_cmp++;
                if (od_q[b_od+i] !== W'(31 + 3 * i) || ol_q[b_od+i] !== (i == 23)) begin
                    n_fail++;
                    $display("FAIL ovf_out%0d: got %0d/last %b required %0d/last %b",
                             i, od_q[b_od+i], ol_q[b_od+i], 31 + 3 * i, (i == 23));
                end
            end
        end
    endtask

    task automatic test_timeout();
        int b_od, b_fl, b_clr;
        b_od = od_q.size(); b_fl = fl_cyc.size(); b_clr = clr_cyc.size();
        mute = 1'b1;
        frm = '{8'd4, 8'd2, 8'd7};
        send_frame();
        wait_done(300, "tmo");
        mute = 1'b0;
        n_cmp++;
        if (err_timeout !== 1'b1 || err_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL tmo_flags: tmo=%b ovf=%b required 1/1", err_timeout, err_overflow);
        end
        n_cmp++;
        if (od_q.size() != b_od || fl_cyc.size() - b_fl != 3) begin
            n_fail++;
            $display("FAIL tmo_traffic: outs=%0d flushes=%0d required 0/3", od_q.size() - b_od, fl_cyc.size() - b_fl);
        end
        n_cmp++;
        if (clr_cyc.size() - b_clr != 1 || fl_cyc.size() <= b_fl) begin
            n_fail++;
            $display("FAIL tmo_clear: clears=%0d required 1", clr_cyc.size() - b_clr);
        end else if (clr_cyc[b_clr] - fl_cyc[b_fl] != 64) begin
            n_fail++;
            $display("FAIL tmo_timing: clear %0d cycles after drain start required 64",
                     clr_cyc[b_clr] - fl_cyc[b_fl]);
        end
    endtask

    task automatic test_reset_midframe();
        int b_od;
        frm = '{8'd30, 8'd20};
        send_frame();
        in_data  = 8'd10;
        in_valid = 1'b1;
        nreset   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if ({srt_clear, in_ready, srt_valid, srt_flush, out_valid, out_last, busy} !== 7'b1000000) begin
            n_fail++;
            $display("FAIL mid_reset: got %b required 1000000",
                     {srt_clear, in_ready, srt_valid, srt_flush, out_valid, out_last, busy});
        end
        n_cmp++;
        if ({err_overflow, err_timeout} !== 2'b00) begin
            n_fail++;
            $display("FAIL mid_err: got %b required 00", {err_overflow, err_timeout});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        nreset   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        b_od = od_q.size();
        frm = '{8'd8, 8'd6, 8'd7};
        send_frame();
        wait_done(300, "mid");
        n_cmp++;
        if (od_q.size() - b_od != 3) begin
            n_fail++;
            $display("FAIL mid_count: got %0d required 3", od_q.size() - b_od);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (od_q[b_od+i] !== W'(6 + i) || ol_q[b_od+i] !== (i == 2)) begin
                    n_fail++;
                    $display("FAIL mid_out%0d: got %0d/last %b required %0d/last %b",
                             i, od_q[b_od+i], ol_q[b_od+i], 6 + i, (i == 2));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_exact_n();
        test_back_to_back();
        test_backpressure();
        test_overflow();
        test_timeout();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
